// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: flag register, condition evaluation and taken-branch redirect/link/flush
// Ports: clk, rst (async, active-high); flag_we with carry/zero/sign/ovf_in update {C,Z,N,V};
// br_valid, br_cond, br_target, pc_plus1, is_call describe the branch in the resolve stage;
// flags, redirect_valid/redirect_pc, flush, link_we/link_data and taken_count are the results.
module branch_resolve_unit #(
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag_we,
    input  logic                 carry_in,
    input  logic                 zero_in,
    input  logic                 sign_in,
    input  logic                 ovf_in,
    input  logic                 br_valid,
    input  logic [3:0]           br_cond,
    input  logic [PC_WIDTH-1:0]  br_target,
    input  logic [PC_WIDTH-1:0]  pc_plus1,
    input  logic                 is_call,
    output logic [3:0]           flags,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 flush,
    output logic                 link_we,
    output logic [PC_WIDTH-1:0]  link_data,
    output logic [CNT_WIDTH-1:0] taken_count
);
    typedef enum logic {IDLE, FLUSH} state_t;
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
    state_t               state_q;
    logic [3:0]           cnt_q;
    logic [3:0]           flags_q, new_flags, eff;
    logic [15:0]          cond_vec;
    logic                 c, z, n, v, taken;
    logic                 redirect_valid_q, link_we_q;
    logic [PC_WIDTH-1:0]  redirect_pc_q, link_data_q;
    logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;
    assign new_flags = {carry_in, zero_in, sign_in, ovf_in};
    // Same-cycle bypass: a branch alongside a flag write sees the new flags.
    assign eff = flag_we ? new_flags : flags_q;
    assign {c, z, n, v} = eff;
    // Bit i is the outcome of condition code i.
    assign cond_vec = {1'b0, ~c | z, c & ~z, z | (n ^ v), ~z & ~(n ^ v), ~(n ^ v), n ^ v,
                       ~v, v, ~n, n, ~z, z, ~c, c, 1'b1};
    assign taken = br_valid & cond_vec[br_cond] & (state_q == IDLE);
    assign taken_count_d = (&taken_count_q) ? taken_count_q : taken_count_q + CNT_WIDTH'(1);
    assign flags          = flags_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = state_q == FLUSH;
    assign link_we        = link_we_q;
    assign link_data      = link_data_q;
    assign taken_count    = taken_count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            flags_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            link_we_q        <= 1'b0;
            link_data_q      <= '0;
            taken_count_q    <= '0;
        end else begin
            redirect_valid_q <= taken;
            link_we_q        <= taken & is_call;
            // Flag writes arriving during a flush belong to squashed instructions.
            if (state_q == IDLE && flag_we)
                flags_q <= new_flags;
            if (taken) begin
                state_q       <= FLUSH;
                cnt_q         <= CNT_INIT;
                redirect_pc_q <= br_target;
                taken_count_q <= taken_count_d;
                if (is_call)
                    link_data_q <= pc_plus1;
            end else if (state_q == FLUSH) begin
                if (cnt_q == 4'd0)
                    state_q <= IDLE;
                else
                    cnt_q <= cnt_q - 4'd1;
            end
        end
    end
endmodule
